// File: rtl/cluster_slot_packer_if.sv
// Bus between the cluster finder, the slot packer and the trigger link logic.
// Carries ovf_count only when CLUSTER_PACKER_OVF_COUNTER_EN is defined.
interface cluster_slot_packer_if;
  logic        bx_strobe;
  logic [13:0] clst_a;
  logic        clst_a_vld;
  logic [13:0] clst_b;
  logic        clst_b_vld;
  logic [13:0] cluster0;
  logic [13:0] cluster1;
  logic [13:0] cluster2;
  logic [13:0] cluster3;
  logic [13:0] cluster4;
  logic [13:0] cluster5;
  logic [13:0] cluster6;
  logic [13:0] cluster7;
  logic        overflow;
  logic        frame_strobe;
`ifdef CLUSTER_PACKER_OVF_COUNTER_EN
  logic [15:0] ovf_count;
`endif

  modport master (
`ifdef CLUSTER_PACKER_OVF_COUNTER_EN
    input  ovf_count,
`endif
    output bx_strobe, clst_a, clst_a_vld, clst_b, clst_b_vld,
    input  cluster0, cluster1, cluster2, cluster3,
    input  cluster4, cluster5, cluster6, cluster7,
    input  overflow, frame_strobe
  );

  modport slave (
`ifdef CLUSTER_PACKER_OVF_COUNTER_EN
    output ovf_count,
`endif
    input  bx_strobe, clst_a, clst_a_vld, clst_b, clst_b_vld,
    output cluster0, cluster1, cluster2, cluster3,
    output cluster4, cluster5, cluster6, cluster7,
    output overflow, frame_strobe
  );
endinterface

// File: rtl/cluster_slot_packer.sv
// Packs up to two cluster candidates per clk_160 cycle into eight slots per BX window.
// Optional saturating overflow-window counter: define CLUSTER_PACKER_OVF_COUNTER_EN.
module cluster_slot_packer #(
  parameter int         NSLOTS      = 8,
  parameter logic [10:0] INVALID_ADR = 11'h7FE
) (
  input  logic                 clk_160,
  input  logic                 reset,
  cluster_slot_packer_if.slave bus
);
  localparam int DATA_W = 14;
  localparam logic [DATA_W-1:0] EMPTY = {3'b000, INVALID_ADR};
  localparam logic [3:0] FULL = 4'(NSLOTS);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic qualify(input logic vld, input logic [DATA_W-1:0] c);
    return vld && (c[10:0] < 11'h7FE);
  endfunction

`ifdef CLUSTER_PACKER_OVF_COUNTER_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic [DATA_W-1:0] acc_p0 [NSLOTS];
  logic [DATA_W-1:0] acc_nx [NSLOTS];
  logic [3:0]        fill_p0, fill_nx;
  logic              ovf_acc_p0, ovf_acc_nx;
  logic              take_a, take_b;

  logic [DATA_W-1:0] slot_p1 [NSLOTS];
  logic              overflow_p1;
  logic              frame_p1;

  state_t state_q, state_d;
  logic   frame_d;

  // Stage p0: the strobe restarts the window before this cycle's candidates are placed
  always_comb begin
    take_a = qualify(bus.clst_a_vld, bus.clst_a);
    take_b = qualify(bus.clst_b_vld, bus.clst_b);
    for (int i = 0; i < NSLOTS; i++) acc_nx[i] = bus.bx_strobe ? EMPTY : acc_p0[i];
    fill_nx    = bus.bx_strobe ? 4'd0 : fill_p0;
    ovf_acc_nx = bus.bx_strobe ? 1'b0 : ovf_acc_p0;
    if (take_a) begin
      if (fill_nx < FULL) begin
        acc_nx[fill_nx[2:0]] = bus.clst_a;
        fill_nx = fill_nx + 4'd1;
      end else begin
        ovf_acc_nx = 1'b1;
      end
    end
    if (take_b) begin
      if (fill_nx < FULL) begin
        acc_nx[fill_nx[2:0]] = bus.clst_b;
        fill_nx = fill_nx + 4'd1;
      end else begin
        ovf_acc_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_160 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOTS; i++) acc_p0[i] <= EMPTY;
      fill_p0    <= 4'd0;
      ovf_acc_p0 <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOTS; i++) acc_p0[i] <= acc_nx[i];
      fill_p0    <= fill_nx;
      ovf_acc_p0 <= ovf_acc_nx;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = 1'b0;
    case (state_q)
      IDLE:    if (bus.bx_strobe) state_d = RUN;
      RUN:     frame_d = bus.bx_strobe;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_160 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stage p1: published slots, held stable until the next strobe
  always_ff @(posedge clk_160 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOTS; i++) slot_p1[i] <= EMPTY;
      overflow_p1 <= 1'b0;
      frame_p1    <= 1'b0;
    end else begin
      frame_p1 <= frame_d;
      if (bus.bx_strobe) begin
        for (int i = 0; i < NSLOTS; i++) slot_p1[i] <= acc_p0[i];
        overflow_p1 <= ovf_acc_p0;
      end
    end
  end

`ifdef CLUSTER_PACKER_OVF_COUNTER_EN
  logic [15:0] ovf_cnt_p1;

  always_ff @(posedge clk_160 or posedge reset) begin
    if (reset)                           ovf_cnt_p1 <= 16'd0;
    else if (bus.bx_strobe && ovf_acc_p0) ovf_cnt_p1 <= sat_inc16(ovf_cnt_p1);
  end

  assign bus.ovf_count = ovf_cnt_p1;
`endif

  assign bus.cluster0     = slot_p1[0];
  assign bus.cluster1     = slot_p1[1];
  assign bus.cluster2     = slot_p1[2];
  assign bus.cluster3     = slot_p1[3];
  assign bus.cluster4     = slot_p1[4];
  assign bus.cluster5     = slot_p1[5];
  assign bus.cluster6     = slot_p1[6];
  assign bus.cluster7     = slot_p1[7];
  assign bus.overflow     = overflow_p1;
  assign bus.frame_strobe = frame_p1;
endmodule

// File: tb/tb_cluster_slot_packer.sv
// Directed bench for cluster_slot_packer; expected slot contents are written out by hand.
module tb_cluster_slot_packer;
  logic clk_160;
  logic reset;
  int   total;
  int   bad;

  localparam logic [13:0] INV = 14'h07FE;

  cluster_slot_packer_if bus ();

  cluster_slot_packer dut (
    .clk_160 (clk_160),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial clk_160 = 1'b0;
  always #5 clk_160 = ~clk_160;

  logic [13:0] obs_s [8];
  assign obs_s[0] = bus.cluster0;
  assign obs_s[1] = bus.cluster1;
  assign obs_s[2] = bus.cluster2;
  assign obs_s[3] = bus.cluster3;
  assign obs_s[4] = bus.cluster4;
  assign obs_s[5] = bus.cluster5;
  assign obs_s[6] = bus.cluster6;
  assign obs_s[7] = bus.cluster7;

  function automatic logic [111:0] pk(input logic [13:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_slots(input string tag, input logic [111:0] exp, input logic exp_ovf);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s.c%0d", tag, i), 16'(obs_s[i]), 16'(exp[i*14 +: 14]));
    chk({tag, ".ovf"}, 16'(bus.overflow), 16'(exp_ovf));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef CLUSTER_PACKER_OVF_COUNTER_EN
    chk(tag, bus.ovf_count, exp);
`else
    if (exp === 16'hFFFF) $display("%s", tag);
`endif
  endtask

  task automatic drv(input logic s, input logic [13:0] a, input logic av,
                     input logic [13:0] b, input logic bv);
    bus.bx_strobe  = s;
    bus.clst_a     = a;
    bus.clst_a_vld = av;
    bus.clst_b     = b;
    bus.clst_b_vld = bv;
  endtask

  task automatic cyc(input logic s, input logic [13:0] a, input logic av,
                     input logic [13:0] b, input logic bv);
    drv(s, a, av, b, bv);
    @(posedge clk_160);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 14'h0, 1'b0, 14'h0, 1'b0);
  endtask

  task automatic strobe();
    cyc(1'b1, 14'h0, 1'b0, 14'h0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drv(1'b0, 14'h0, 1'b0, 14'h0, 1'b0);
    repeat (2) @(posedge clk_160);
    #1;
    chk_slots("reset", {8{INV}}, 1'b0);
    chk("reset.fs", 16'(bus.frame_strobe), 16'h0);
    chk_cnt("reset.cnt", 16'h0);
    reset = 1'b0;

    // Empty windows; first strobe after reset publishes without frame_strobe
    strobe();
    chk("first.fs", 16'(bus.frame_strobe), 16'h0);
    idle(3);
    strobe();
    chk_slots("empty", {8{INV}}, 1'b0);
    chk("empty.fs", 16'(bus.frame_strobe), 16'h1);
    idle(1);
    chk("empty.fs_drop", 16'(bus.frame_strobe), 16'h0);

    // Three candidates spread over one window
    cyc(1'b1, 14'h0123, 1'b1, 14'h0, 1'b0);
    cyc(1'b0, 14'h0, 1'b0, 14'h1456, 1'b1);
    cyc(1'b0, 14'h2010, 1'b1, 14'h0, 1'b0);
    idle(1);
    strobe();
    chk_slots("three", pk(14'h0123, 14'h1456, 14'h2010, INV, INV, INV, INV, INV), 1'b0);
    idle(1);
    chk("three.hold", 16'(bus.cluster0), 16'h0123);
    chk("three.hold_fs", 16'(bus.frame_strobe), 16'h0);

    // Exactly eight, then a pair in the next strobe cycle
    idle(2);
    cyc(1'b1, 14'h0001, 1'b1, 14'h0002, 1'b1);
    chk_slots("eight.pre", {8{INV}}, 1'b0);
    cyc(1'b0, 14'h0003, 1'b1, 14'h0004, 1'b1);
    cyc(1'b0, 14'h0005, 1'b1, 14'h0006, 1'b1);
    cyc(1'b0, 14'h0007, 1'b1, 14'h0008, 1'b1);
    cyc(1'b1, 14'h0009, 1'b1, 14'h000A, 1'b1);
    chk_slots("eight", pk(14'h0001, 14'h0002, 14'h0003, 14'h0004,
                          14'h0005, 14'h0006, 14'h0007, 14'h0008), 1'b0);
    idle(3);
    strobe();
    chk_slots("carry", pk(14'h0009, 14'h000A, INV, INV, INV, INV, INV, INV), 1'b0);

    // Nine accepted: fill reaches 7, then A takes slot 7 and B overflows
    chk_cnt("ovf.cnt0", 16'h0);
    cyc(1'b0, 14'h0011, 1'b1, 14'h0012, 1'b1);
    cyc(1'b0, 14'h0013, 1'b1, 14'h0014, 1'b1);
    cyc(1'b0, 14'h0015, 1'b1, 14'h0016, 1'b1);
    cyc(1'b0, 14'h0017, 1'b1, 14'h0000, 1'b0);
    cyc(1'b0, 14'h0018, 1'b1, 14'h0019, 1'b1);
    strobe();
    chk_slots("ovf", pk(14'h0011, 14'h0012, 14'h0013, 14'h0014,
                        14'h0015, 14'h0016, 14'h0017, 14'h0018), 1'b1);
    chk_cnt("ovf.cnt1", 16'h1);
    idle(3);
    strobe();
    chk_slots("ovf.clear", {8{INV}}, 1'b0);
    chk_cnt("ovf.cnt_hold", 16'h1);

    // Reserved addresses and invalid flags are dropped without overflow
    cyc(1'b0, 14'h07FE, 1'b1, 14'h17FF, 1'b1);
    cyc(1'b0, 14'h0055, 1'b0, 14'h0056, 1'b0);
    idle(1);
    strobe();
    chk_slots("reserved", {8{INV}}, 1'b0);

    // Reset mid-window discards the partial window and published data
    cyc(1'b0, 14'h0041, 1'b1, 14'h0000, 1'b0);
    idle(2);
    cyc(1'b1, 14'h0031, 1'b1, 14'h0032, 1'b1);
    chk("prereset.c0", 16'(bus.cluster0), 16'h0041);
    cyc(1'b0, 14'h0033, 1'b1, 14'h0000, 1'b0);
    reset = 1'b1;
    #2;
    chk_slots("async_rst", {8{INV}}, 1'b0);
    chk_cnt("async_rst.cnt", 16'h0);
    drv(1'b0, 14'h0, 1'b0, 14'h0, 1'b0);
    @(posedge clk_160);
    #1;
    reset = 1'b0;
    cyc(1'b0, 14'h0051, 1'b1, 14'h0000, 1'b0);
    idle(2);
    strobe();
    chk_slots("post_rst", pk(14'h0051, INV, INV, INV, INV, INV, INV, INV), 1'b0);
    chk("post_rst.fs", 16'(bus.frame_strobe), 16'h0);

    // Back-to-back strobes
    cyc(1'b1, 14'h0061, 1'b1, 14'h0000, 1'b0);
    chk_slots("b2b.first", {8{INV}}, 1'b0);
    chk("b2b.first_fs", 16'(bus.frame_strobe), 16'h1);
    strobe();
    chk_slots("b2b.second", pk(14'h0061, INV, INV, INV, INV, INV, INV, INV), 1'b0);
    chk("b2b.second_fs", 16'(bus.frame_strobe), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cluster_slot_packer.md
# cluster_slot_packer

Collects cluster candidates from the cluster finder, two per `clk_160` cycle, and packs them into the eight fixed 14-bit slots (`cluster0`..`cluster7`) plus the `overflow` flag. These slots drive `trigger_links` once per bunch crossing. A BX-aligned strobe defines each 4-cycle collection window. At the start of each new window the completed window is published, and the outputs hold stable for a full BX so the 40/80 MHz link logic samples clean data.

## Interface
Parameters:
- `NSLOTS`, 8: output slots per BX; only 8 is supported.
- `INVALID_ADR`, 11'h7FE: address code for an empty slot.

Ports:
- `clk_160` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `bx_strobe` in 1: one-cycle pulse on the first `clk_160` cycle of each BX window, nominally every 4 cycles.
- `clst_a` in 14: candidate A, `{cnt[2:0], adr[10:0]}`.
- `clst_a_vld` in 1: candidate A valid.
- `clst_b` in 14: candidate B, same format.
- `clst_b_vld` in 1: candidate B valid.
- `cluster0`..`cluster7` out 14 each: packed slots for the previous window.
- `overflow` out 1: the previous window had more than 8 accepted candidates.
- `frame_strobe` out 1: one-cycle pulse when new slots are published.
- `ovf_count` out 16: saturating overflow-window counter. Present only with `CLUSTER_PACKER_OVF_COUNTER_EN`.

## Operation
- Qualification: a candidate is accepted when its `_vld` is 1 and `adr < 11'h7FE`. Addresses 0x7FE and 0x7FF are dropped silently and never counted as overflow.
- Fill order: a 4-bit fill counter `fill` (0..8) indexes 8 internal accumulator slots. Within a cycle, A is placed before B. Earlier cycles fill lower slots.
- Per-cycle placement with `n` accepted candidates (0, 1 or 2):
  - Each accepted candidate takes the next free slot while `fill < 8`.
  - Any candidate arriving when no slot is free sets the window overflow flag `ovf_acc`.
  - `fill` advances by the number of candidates placed, saturating at 8.
- Example: `fill = 7` with A and B both accepted → A goes to slot 7, `fill = 8`, B sets `ovf_acc`.
- Window boundary, on a cycle with `bx_strobe = 1`:
  - Accumulator slots and `ovf_acc`, as they stand before this cycle's candidates, are copied to the output registers.
  - Unfilled slots are published as `{3'b000, INVALID_ADR}` = 14'h07FE.
  - The accumulator is then cleared to all-invalid, `fill` is set to the count placed this cycle, and this cycle's candidates become slots 0/1 of the new window.
- No strobe: accumulation continues indefinitely. Slots saturate at 8 and any further accepted candidate sets `ovf_acc`.
- Outputs change only on strobe cycles. Between strobes they hold their last published value.
- States: `IDLE` (after reset, until the first strobe; candidates are still accumulated) → `RUN` on the first `bx_strobe`. `RUN` has no exit except `reset`. The only difference between the states is that `frame_strobe` is suppressed for the first strobe after reset.

## Timing
- Latency: a candidate accepted in window N appears on the outputs 1 cycle after the strobe that opens window N+1.
- `frame_strobe` asserts in the same cycle the outputs update, i.e. 1 cycle after `bx_strobe`.
- With strobes every 4 cycles, the outputs are stable for 4 `clk_160` cycles, covering one full `clk_40` period.
- Back-to-back strobes (spacing 1) are legal: each publishes whatever was accumulated in the previous cycle.
- Reset values, applied asynchronously:
  - all `clusterN` = 14'h07FE, `overflow` = 0, `frame_strobe` = 0;
  - `fill` = 0, `ovf_acc` = 0, state `IDLE`;
  - `ovf_count` = 0.
- Reset asserted mid-window discards the partial window. No publish occurs on reset release.

## Configuration
- `CLUSTER_PACKER_OVF_COUNTER_EN` defined:
  - `ovf_count` port and a 16-bit counter are built.
  - The counter increments by 1 on every strobe that publishes `overflow = 1`, saturates at 16'hFFFF, and clears only on `reset`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then strobes every 4 cycles with no candidates → all slots stay 14'h07FE, `overflow = 0`. `frame_strobe` pulses from the second strobe on.
- One window carrying A = 14'h0123 (cycle 0), B = 14'h1456 (cycle 1), A = 14'h2010 (cycle 2) → after the next strobe +1 cycle: `cluster0 = 0123`, `cluster1 = 1456`, `cluster2 = 2010`, `cluster3..7 = 07FE`, `overflow = 0`.
- 4 cycles with both A and B valid, carrying distinct addresses 1..8, then a fifth pair in the strobe cycle of the next window → first publish holds addresses 1..8 in order with `overflow = 0`; the fifth pair lands in slots 0/1 of the following publish.
- 9 accepted candidates within one window → slots hold the first 8, `overflow = 1`. With `CLUSTER_PACKER_OVF_COUNTER_EN`, `ovf_count` goes 0 → 1.
- A valid with `adr = 0x7FE`, B valid with `adr = 0x7FF`, nothing else → publish is all 07FE and `overflow = 0`.
- Reset asserted for 1 cycle mid-window after 3 candidates → outputs return to 07FE immediately. The next publish contains only candidates that arrived after reset release.
